// File: rtl/vga_scan_gen_if.sv
// Framebuffer read port between the VGA scan generator and the synchronous
// framebuffer RAM. The RAM returns fb_data exactly one clock after it sees
// fb_rd_en together with fb_addr. There is no backpressure: a read that is
// issued always completes.
interface vga_scan_gen_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8
);
    logic              fb_rd_en;
    logic [ADDR_W-1:0] fb_addr;
    logic [DATA_W-1:0] fb_data;

    // The scan generator issues reads.
    modport master (
        output fb_rd_en,
        output fb_addr,
        input  fb_data
    );

    // The framebuffer RAM answers them.
    modport slave (
        input  fb_rd_en,
        input  fb_addr,
        output fb_data
    );
endinterface

// File: rtl/vga_scan_gen.sv
// 640x480@60 Hz VGA timing and scan generator.
// S0: raster counters and decode. S1: framebuffer read request.
// S2: RAM data returns. S3: registered rgb/hsync/vsync to the DAC.
// Sync and pixel data travel through the same pipeline, so they always
// leave the block together, 3 clocks after the counters show a position.
module vga_scan_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int FB_ADDR_W = 19,
    parameter int DATA_W    = 8
) (
    input  logic                clk_25MHz,
    input  logic                rst,
    vga_scan_gen_if.master      fb,
    output logic [9:0]          vga_row,
    output logic [9:0]          vga_col,
    output logic                frame_start,
    output logic [DATA_W-1:0]   vga_rgb,
    output logic                vga_hs,
    output logic                vga_vs
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_ACT_END  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    // S0 decode
    logic row_last;
    logic col_last;
    logic active_s0;
    logic hs_n_s0;
    logic vs_n_s0;

    // Pipeline side-band: active flag and active-low syncs per stage
    logic act_s1, hs_n_s1, vs_n_s1;
    logic act_s2, hs_n_s2, vs_n_s2;

    // Raster counters: row runs every clock, col steps when row wraps.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            vga_row <= '0;
            vga_col <= '0;
        end else if (row_last) begin
            vga_row <= '0;
            vga_col <= col_last ? 10'd0 : vga_col + 10'd1;
        end else begin
            vga_row <= vga_row + 10'd1;
        end
    end

    // Position decode of the current counter values.
    always_comb begin
        row_last    = (vga_row == H_LAST);
        col_last    = (vga_col == V_LAST);
        active_s0   = (vga_row < H_ACT_END) && (vga_col < V_ACT_END);
        hs_n_s0     = !((vga_row >= HS_START) && (vga_row < HS_END));
        vs_n_s0     = !((vga_col >= VS_START) && (vga_col < VS_END));
        frame_start = (vga_row == 10'd0) && (vga_col == 10'd0);
    end

    // S1: read request. Active pixels arrive in raster order starting at
    // (0,0), so the address is a running count restarted at frame start and
    // always equals col*H_VISIBLE + row.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            fb.fb_rd_en <= 1'b0;
            fb.fb_addr  <= '0;
            act_s1      <= 1'b0;
            hs_n_s1     <= 1'b1;
            vs_n_s1     <= 1'b1;
        end else begin
            fb.fb_rd_en <= active_s0;
            if (active_s0) begin
                fb.fb_addr <= frame_start ? '0 : fb.fb_addr + FB_ADDR_W'(1);
            end
            act_s1  <= active_s0;
            hs_n_s1 <= hs_n_s0;
            vs_n_s1 <= vs_n_s0;
        end
    end

    // S2: RAM is producing data; delay the side-band to match.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            act_s2  <= 1'b0;
            hs_n_s2 <= 1'b1;
            vs_n_s2 <= 1'b1;
        end else begin
            act_s2  <= act_s1;
            hs_n_s2 <= hs_n_s1;
            vs_n_s2 <= vs_n_s1;
        end
    end

    // S3: registered DAC outputs; blanked pixels are forced to zero.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            vga_rgb <= '0;
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
        end else begin
            vga_rgb <= act_s2 ? fb.fb_data : '0;
            vga_hs  <= hs_n_s2;
            vga_vs  <= vs_n_s2;
        end
    end
endmodule

// File: tb/tb_vga_scan_gen.sv
// Bench for vga_scan_gen. Horizontal timing is the full 800-clock line; the
// frame is shortened to 57 lines so whole frames fit in a short run.
// The reference model derives every expected output from the number of
// clocks since reset released, using the raster rules directly.
module tb_vga_scan_gen;
    localparam int HV = 640, HF = 16, HS = 96, HB = 48;
    localparam int VV = 48,  VF = 3,  VS = 2,  VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int AW = 19;
    localparam int DW = 8;

    logic          clk_25MHz = 1'b0;
    logic          rst = 1'b1;
    logic [9:0]    vga_row;
    logic [9:0]    vga_col;
    logic          frame_start;
    logic [DW-1:0] vga_rgb;
    logic          vga_hs;
    logic          vga_vs;

    logic [7:0]    key = 8'h00;
    logic          force_ff = 1'b0;
    logic [7:0]    ram_q = 8'h00;

    int vectors = 0;
    int miscompares = 0;
    int k = 0;
    int m_addr = 0;
    int rd_cnt = 0;
    int vs_cnt = 0;
    int hs_cnt = 0;

    // clock/reset block
    always #20 clk_25MHz = ~clk_25MHz;

    vga_scan_gen_if #(.ADDR_W(AW), .DATA_W(DW)) fb ();

    vga_scan_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .FB_ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk_25MHz   (clk_25MHz),
        .rst         (rst),
        .fb          (fb),
        .vga_row     (vga_row),
        .vga_col     (vga_col),
        .frame_start (frame_start),
        .vga_rgb     (vga_rgb),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs)
    );

    // Framebuffer RAM model: word at address a holds a[7:0]^key; when no
    // read is issued the output bus carries random garbage.
    always @(posedge clk_25MHz) begin
        if (fb.fb_rd_en) ram_q <= fb.fb_addr[7:0] ^ key;
        else             ram_q <= 8'($urandom);
    end
    assign fb.fb_data = force_ff ? 8'hFF : ram_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    function automatic bit is_active(input int n);
        return ((n % HT) < HV) && (((n / HT) % VT) < VV);
    endfunction

    function automatic int addr_of(input int n);
        return ((n / HT) % VT) * HV + (n % HT);
    endfunction

    // One clock: advance the model, then compare every output at negedge.
    task automatic tick();
        int x, y, x3, y3;
        logic [7:0] e_rgb;
        logic e_hs, e_vs, e_rd;
        @(posedge clk_25MHz);
        k = rst ? 0 : k + 1;
        @(negedge clk_25MHz);
        x = k % HT;
        y = (k / HT) % VT;
        check("row", vga_row, x);
        check("col", vga_col, y);
        check("frame_start", frame_start, (x == 0 && y == 0) ? 1 : 0);

        if (k == 0) begin
            e_rd   = 1'b0;
            m_addr = 0;
        end else begin
            e_rd = is_active(k - 1);
            if (e_rd) m_addr = addr_of(k - 1);
        end
        check("fb_rd_en", fb.fb_rd_en, e_rd);
        check("fb_addr", fb.fb_addr, m_addr);

        if (k < 3) begin
            e_rgb = 8'h00;
            e_hs  = 1'b1;
            e_vs  = 1'b1;
        end else begin
            x3    = (k - 3) % HT;
            y3    = ((k - 3) / HT) % VT;
            e_rgb = !is_active(k - 3) ? 8'h00 :
                    force_ff ? 8'hFF : (8'(addr_of(k - 3)) ^ key);
            e_hs  = !(x3 >= HV + HF && x3 < HV + HF + HS);
            e_vs  = !(y3 >= VV + VF && y3 < VV + VF + VS);
        end
        check("rgb", vga_rgb, e_rgb);
        check("hs", vga_hs, e_hs);
        check("vs", vga_vs, e_vs);

        if (!rst && k >= 1 && k <= FRAME && fb.fb_rd_en) rd_cnt++;
        if (!rst && k >= 3 && k <= FRAME + 2 && !vga_vs) vs_cnt++;
        if (!rst && k >= 3 && k <= HT + 2 && !vga_hs) hs_cnt++;
    endtask

    task automatic run_to(input int target);
        while (k < target) tick();
    endtask

    initial begin
        int y_rst;
        key      = 8'($urandom_range(0, 255));
        force_ff = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_row", vga_row, 0);
        check("rst_col", vga_col, 0);
        check("rst_frame_start", frame_start, 1);
        check("rst_rd_en", fb.fb_rd_en, 0);
        check("rst_addr", fb.fb_addr, 0);
        check("rst_rgb", vga_rgb, 0);
        check("rst_hs", vga_hs, 1);
        check("rst_vs", vga_vs, 1);

        // Full frame with address-pattern RAM
        rd_cnt = 0; vs_cnt = 0; hs_cnt = 0;
        rst = 1'b0;
        run_to(3);
        check("rgb_0_0", vga_rgb, 8'h00 ^ key);
        run_to(639 + 3);
        check("rgb_639_0", vga_rgb, 8'h7F ^ key);
        run_to(656 + 2);
        check("hs_before_pulse", vga_hs, 1);
        tick();
        check("hs_first_low", vga_hs, 0);
        run_to(751 + 3);
        check("hs_last_low", vga_hs, 0);
        tick();
        check("hs_after_pulse", vga_hs, 1);
        run_to(HT + 3);
        check("rgb_0_1", vga_rgb, 8'h80 ^ key);
        check("hs_low_per_line", hs_cnt, HS);
        run_to(10 * HT + 799);
        check("wrap10_row", vga_row, 799);
        check("wrap10_col", vga_col, 10);
        tick();
        check("wrap11_row", vga_row, 0);
        check("wrap11_col", vga_col, 11);
        run_to((VV - 1) * HT + (HV - 1) + 3);
        check("rgb_last_pixel", vga_rgb, 8'hFF ^ key);
        run_to(FRAME - 2);
        check("fw_a_row", vga_row, HT - 2);
        check("fw_a_col", vga_col, VT - 1);
        tick();
        check("fw_b_row", vga_row, HT - 1);
        check("fw_b_col", vga_col, VT - 1);
        tick();
        check("fw_c_row", vga_row, 0);
        check("fw_c_col", vga_col, 0);
        check("fw_c_frame_start", frame_start, 1);
        tick();
        check("fw_d_row", vga_row, 1);
        check("fw_d_frame_start", frame_start, 0);
        run_to(FRAME + 2);
        check("rd_en_per_frame", rd_cnt, HV * VV);
        check("vs_low_per_frame", vs_cnt, VS * HT);

        // Constant 0xFF on the RAM bus: blanking must still read zero
        rst = 1'b1;
        force_ff = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        run_to(5 * HT + 700);
        check("ff_blank_rgb", vga_rgb, 0);
        run_to(6 * HT + 100 + 3);
        check("ff_active_rgb", vga_rgb, 8'hFF);
        run_to(12 * HT + 10);

        // One-clock reset in the middle of an hsync pulse
        rst = 1'b1;
        force_ff = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        y_rst = $urandom_range(2, 15);
        run_to(y_rst * HT + 700);
        check("pre_rst_row", vga_row, 700);
        check("pre_rst_hs", vga_hs, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_row", vga_row, 0);
        check("mid_rst_col", vga_col, 0);
        check("mid_rst_hs", vga_hs, 1);
        check("mid_rst_vs", vga_vs, 1);
        check("mid_rst_rgb", vga_rgb, 0);
        tick();
        check("post_rst_hs", vga_hs, 1);
        run_to(3);
        check("post_rst_first_rgb", vga_rgb, 8'h00 ^ key);
        run_to(2 * HT + 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/vga_scan_gen.md
Name: vga_scan_gen

Overview:
- Timing/scan generator for the 640x480@60 Hz VGA path.
- Owns the horizontal (vga_row) and vertical (vga_col) position counters and issues framebuffer read requests one pixel ahead of display.
- Drives the monitor-facing rgb/hsync/vsync with sync and pixel data aligned through a fixed pipeline.
- Produces the row/col stream that the display output stage consumes.
- Sits between clk_25MHz pixel-clock logic and the synchronous framebuffer RAM.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync pulse width
H_BACK, 48, horizontal back porch
V_VISIBLE, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BACK, 33, vertical back porch
FB_ADDR_W, 19, framebuffer word-address width

Ports:
clk_25MHz  input  1  pixel clock
rst  input  1  synchronous active-high reset
fb_data  input  `VGA_DATA_BUS  framebuffer read data, valid exactly 1 clock after fb_rd_en
vga_row  output  `VGA_ROW_BUS (10b)  horizontal counter, 0..799 (stage S0)
vga_col  output  `VGA_COL_BUS (10b)  vertical counter, 0..524 (stage S0)
fb_rd_en  output  1  framebuffer read strobe (stage S1)
fb_addr  output  FB_ADDR_W  framebuffer pixel address (stage S1)
frame_start  output  1  one-clock pulse while counters = (0,0) (stage S0)
vga_rgb  output  `VGA_DATA_BUS  pixel to DAC (stage S3)
vga_hs  output  1  hsync, active low (stage S3)
vga_vs  output  1  vsync, active low (stage S3)

Behaviour:
- Single clock domain clk_25MHz. Reset is synchronous and active-high: rst sampled only on the rising edge; no asynchronous paths.
- Reset values:
  - vga_row = 0, vga_col = 0.
  - fb_rd_en = 0, fb_addr = 0.
  - vga_rgb = 0, vga_hs = 1, vga_vs = 1.
  - All S1..S3 pipeline valid/sync bits at their inactive value.
  - frame_start follows the counters, so it reads 1 while reset holds them at (0,0).
- Counters (S0):
  - H_TOTAL = 800 and V_TOTAL = 525, both derived from the parameters.
  - vga_row increments every clock and wraps H_TOTAL-1 -> 0.
  - vga_col increments only on the clock where vga_row wraps; vga_col wraps V_TOTAL-1 -> 0 on the same clock vga_row wraps.
- Decode (from S0 values):
  - active = (vga_row < H_VISIBLE) && (vga_col < V_VISIBLE).
  - hs_n = 0 iff H_VISIBLE+H_FRONT <= vga_row < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
  - vs_n = 0 iff V_VISIBLE+V_FRONT <= vga_col < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491.
- S1 (registered):
  - fb_rd_en <= active.
  - fb_addr <= vga_col*H_VISIBLE + vga_row when active; holds its last value otherwise.
  - Maximum fb_addr is 307199. An incremental implementation is acceptable: clear on frame start, +1 per active pixel. The value must equal the formula.
  - active, hs_n and vs_n are delayed alongside.
- S2: fb_data is valid (1-cycle synchronous RAM). active/hs/vs are delayed one more stage.
- S3 (registered outputs):
  - vga_rgb <= active_S2 ? fb_data : 0.
  - vga_hs <= hs_S2, vga_vs <= vs_S2.
- Latency: the outputs for counter position (x,y) appear exactly 3 clocks after the counters show (x,y). Sync and rgb are never misaligned relative to each other.
- Blanking: vga_rgb is 0 on every non-active pixel regardless of fb_data. fb_rd_en is never asserted outside the visible area.
- Reset mid-frame:
  - Next clock: counters go to (0,0) and all pipeline stages clear.
  - No partial sync pulse or stale pixel is emitted after rst deasserts.
  - The first valid rgb appears 3 clocks after release.
- Wrap boundaries:
  - (799,524) -> (0,0) on one clock; frame_start pulses for exactly that next clock.
  - (799,y) -> (0,y+1) for y < 524.
- Period: exactly 800 clocks per line and 420000 clocks per frame, with no gaps.

Test Plan:
- Reset release, run 1 frame -> frame_start high at clocks 0 and 420000 only; vga_row/vga_col = (0,0) at both.
- Count hsync -> vga_hs low for 96 consecutive clocks per line, first low 3 clocks after vga_row = 656; vga_vs low for exactly 1600 clocks per frame, starting with vga_col = 490.
- Model RAM returns fb_data = fb_addr[7:0] -> vga_rgb at output position (x,y) equals (y*640+x)[7:0]; check (0,0)=0x00, (639,0)=0x7F, (0,1)=0x80, (639,479)=0xFF (addr 307199).
- Force fb_data = 0xFF constantly -> vga_rgb = 0 for all positions with x >= 640 or y >= 480; fb_rd_en asserted exactly 307200 times per frame.
- Assert rst for 1 clock at (700,300) mid-hsync -> vga_hs and vga_vs = 1 and vga_rgb = 0 on the following clocks; counters restart at (0,0); first pixel (0,0) appears 3 clocks after release.
- Wrap check -> sequence (798,524), (799,524), (0,0), (1,0) on consecutive clocks, and (799,10) -> (0,11).
